// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : Shared types and constants for the compute-unit wave dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALC     = 2'd1,
        ST_DISPATCH = 2'd2,
        ST_DRAIN    = 2'd3
    } disp_state_t;

    localparam int unsigned DEF_NUM_SIMD  = 2;
    localparam int unsigned DEF_WAVE_SIZE = 32;

    // Right-shift that divides a thread count by the (power-of-2) wave size.
    function automatic int wave_shift(input int wave_size);
        return $clog2(wave_size);
    endfunction

    // Pointer width for an N-entry round-robin; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/rr_free_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_free_arbiter
// Purpose  : Combinational round-robin pick of the first non-busy SIMD,
//            searching upward from the pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_free_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_SIMD = DEF_NUM_SIMD
) (
    input  logic [NUM_SIMD-1:0]            busy,
    input  logic [ptr_width(NUM_SIMD)-1:0] ptr,
    output logic [NUM_SIMD-1:0]            grant,
    output logic                           found
);

    logic [NUM_SIMD-1:0] rot_busy;
    logic [NUM_SIMD-1:0] rot_grant;

    // Rotate so the pointer sits at bit 0, priority-pick, then rotate back.
    always_comb begin
        rot_busy  = NUM_SIMD'({busy, busy} >> ptr);
        rot_grant = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SIMD; k++) begin
            if (!found && !rot_busy[k]) begin
                rot_grant[k] = 1'b1;
                found        = 1'b1;
            end
        end
        grant = NUM_SIMD'(({rot_grant, rot_grant} << ptr) >> NUM_SIMD);
    end

endmodule : rr_free_arbiter
`default_nettype wire

// File: rtl/wave_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : wave_dispatcher
// Purpose  : Splits a thread block into wavefronts and issues them round-robin
//            to NUM_SIMD SIMD units. Optional perf counters: WAVE_DISPATCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wave_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_SIMD  = DEF_NUM_SIMD,
    parameter int WAVE_SIZE = DEF_WAVE_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         num_threads,
    input  logic [31:0]         block_dim,
    input  logic                blk_valid,
    input  logic signed [31:0]  blk_id,
    output logic                blk_ready,
    output logic                blk_done,
    output logic [NUM_SIMD-1:0] simd_start,
    output logic [NUM_SIMD-1:0] simd_ready,
    input  logic [NUM_SIMD-1:0] simd_done,
    output logic signed [31:0]  block_id,
    output logic [31:0]         num_waves_in_block,
    output logic signed [31:0]  wave_id [NUM_SIMD]
`ifdef WAVE_DISPATCH_PERF_EN
    ,
    output logic [31:0]         perf_waves_issued,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int PTR_W      = ptr_width(NUM_SIMD);
    localparam int WAVE_SHIFT = wave_shift(WAVE_SIZE);

    disp_state_t         state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [31:0]         next_wave;
    logic [NUM_SIMD-1:0] grant;
    logic                found;

    logic [31:0]         base;
    logic [31:0]         rem;
    logic [31:0]         threads;
    logic [32:0]         waves_sum;
    logic [31:0]         waves_calc;
    logic [31:0]         issue_idx;
    logic [31:0]         issue_num;
    logic                can_issue;
    logic                last_wave;

    rr_free_arbiter #(
        .NUM_SIMD (NUM_SIMD)
    ) u_arb (
        .busy  (simd_ready),
        .ptr   (ptr),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        base    = $unsigned(block_id) * block_dim;
        rem     = num_threads - base;
        threads = '0;
        if (base < num_threads) begin
            threads = (rem < block_dim) ? rem : block_dim;
        end
        waves_sum  = {1'b0, threads} + 33'(WAVE_SIZE - 1);
        waves_calc = 32'(waves_sum >> WAVE_SHIFT);
    end

    // Wave 0 is issued on the CALC exit edge so its start lands in the first
    // DISPATCH cycle; every later wave is issued from DISPATCH.
    always_comb begin
        issue_idx = (state == ST_CALC) ? 32'd0 : next_wave;
        issue_num = (state == ST_CALC) ? waves_calc : num_waves_in_block;
        can_issue = found && (((state == ST_CALC) && (waves_calc != 32'd0)) ||
                              (state == ST_DISPATCH));
        last_wave = (issue_idx == issue_num - 32'd1);
    end

    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < NUM_SIMD; i++) begin
            if (grant[i]) begin
                ptr_next = PTR_W'((i + 1) % NUM_SIMD);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            blk_ready          <= 1'b0;
            blk_done           <= 1'b0;
            simd_start         <= '0;
            simd_ready         <= '0;
            block_id           <= '0;
            num_waves_in_block <= '0;
            next_wave          <= '0;
            ptr                <= '0;
            for (int i = 0; i < NUM_SIMD; i++) begin
                wave_id[i] <= '0;
            end
        end else begin
            blk_done   <= 1'b0;
            simd_start <= '0;
            simd_ready <= (simd_ready & ~simd_done) | (can_issue ? grant : '0);

            if (can_issue) begin
                simd_start <= grant;
                ptr        <= ptr_next;
                next_wave  <= issue_idx + 32'd1;
                for (int i = 0; i < NUM_SIMD; i++) begin
                    if (grant[i]) begin
                        wave_id[i] <= $signed(issue_idx);
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (blk_valid && blk_ready) begin
                        block_id  <= blk_id;
                        blk_ready <= 1'b0;
                        state     <= ST_CALC;
                    end else begin
                        blk_ready <= 1'b1;
                    end
                end
                ST_CALC: begin
                    num_waves_in_block <= waves_calc;
                    if (waves_calc == 32'd0) begin
                        blk_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (can_issue && last_wave) begin
                        state <= ST_DRAIN;
                    end else begin
                        state <= ST_DISPATCH;
                        if (!can_issue) begin
                            next_wave <= '0;
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (can_issue && last_wave) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (simd_ready == '0) begin
                        blk_done <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WAVE_DISPATCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_waves_issued <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_waves_issued <= perf_waves_issued + 32'($countones(simd_start));
            if ((state == ST_DISPATCH) && !found) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule : wave_dispatcher
`default_nettype wire

// File: tb/tb_wave_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_dispatcher
// Purpose  : Self-checking bench for wave_dispatcher with a transaction-level
//            reference model and randomized SIMD completion timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_dispatcher;

    localparam int NS = 2;
    localparam int WS = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        num_threads;
    logic [31:0]        block_dim;
    logic               blk_valid;
    logic signed [31:0] blk_id;
    logic               blk_ready;
    logic               blk_done;
    logic [NS-1:0]      simd_start;
    logic [NS-1:0]      simd_ready;
    logic [NS-1:0]      simd_done;
    logic signed [31:0] block_id;
    logic [31:0]        num_waves_in_block;
    logic signed [31:0] wave_id [NS];
`ifdef WAVE_DISPATCH_PERF_EN
    logic [31:0]        perf_waves_issued;
    logic [31:0]        perf_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;

    wave_dispatcher #(
        .NUM_SIMD  (NS),
        .WAVE_SIZE (WS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .num_threads        (num_threads),
        .block_dim          (block_dim),
        .blk_valid          (blk_valid),
        .blk_id             (blk_id),
        .blk_ready          (blk_ready),
        .blk_done           (blk_done),
        .simd_start         (simd_start),
        .simd_ready         (simd_ready),
        .simd_done          (simd_done),
        .block_id           (block_id),
        .num_waves_in_block (num_waves_in_block),
        .wave_id            (wave_id)
`ifdef WAVE_DISPATCH_PERF_EN
        ,
        .perf_waves_issued  (perf_waves_issued),
        .perf_stall_cycles  (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wave count straight from the block geometry, using 64-bit arithmetic.
    function automatic longint unsigned model_waves(input logic signed [31:0] bid,
                                                    input logic [31:0] nt,
                                                    input logic [31:0] bd);
        longint unsigned b, base, thr;
        b    = {32'd0, bid};
        base = (b * {32'd0, bd}) % 64'h1_0000_0000;
        if (base >= {32'd0, nt}) thr = 0;
        else if ({32'd0, bd} < {32'd0, nt} - base) thr = {32'd0, bd};
        else thr = {32'd0, nt} - base;
        return (thr + WS - 1) / WS;
    endfunction

    task automatic run_block(input logic signed [31:0] bid, input int hmin, input int hmax);
        longint unsigned n;
        int issued, guard, sel, stalls, j;
        bit busy_m [NS];
        bit busy_nx [NS];
        bit done_m [NS];
        int timer [NS];
        bit first, exp_done, finished;
        logic [NS-1:0] exp_start_v, exp_ready_v, done_v;
`ifdef WAVE_DISPATCH_PERF_EN
        logic [31:0] pw0, ps0;
`endif
        n = model_waves(bid, num_threads, block_dim);
        issued = 0; stalls = 0; first = 1'b1; finished = 1'b0;
        for (int i = 0; i < NS; i++) begin busy_m[i] = 1'b0; timer[i] = 0; end
        guard = 0;
        while (blk_ready !== 1'b1 && guard < 8) begin tick(); guard++; end
        chk("ready_before_offer", 64'(blk_ready), 64'd1);
`ifdef WAVE_DISPATCH_PERF_EN
        pw0 = perf_waves_issued; ps0 = perf_stall_cycles;
`endif
        blk_valid = 1'b1; blk_id = bid;
        tick();
        blk_valid = 1'b0; blk_id = $urandom;
        chk("accept_ready_low", 64'(blk_ready), 64'd0);
        chk("latched_block_id", block_id, bid);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            for (int i = 0; i < NS; i++) begin
                done_m[i] = busy_m[i] ? (timer[i] == 0) : ($urandom_range(0, 3) == 0);
                if (busy_m[i] && timer[i] > 0) timer[i]--;
            end
            sel = -1; exp_done = 1'b0;
            if (first && n == 0) begin
                exp_done = 1'b1;
            end else if (issued < n) begin
                for (int k = 0; k < NS; k++) begin
                    j = (ptr_m + k) % NS;
                    if (sel < 0 && !busy_m[j]) sel = j;
                end
                if (sel < 0 && !first) stalls++;
            end else begin
                exp_done = 1'b1;
                for (int i = 0; i < NS; i++) if (busy_m[i]) exp_done = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                busy_nx[i]     = (busy_m[i] && !done_m[i]) || (i == sel);
                done_v[i]      = done_m[i];
                exp_start_v[i] = (i == sel);
                exp_ready_v[i] = busy_nx[i];
            end
            simd_done = done_v;
            tick();
            simd_done = '0;
            chk("simd_start", 64'(simd_start), 64'(exp_start_v));
            chk("simd_ready", 64'(simd_ready), 64'(exp_ready_v));
            chk("blk_done", 64'(blk_done), 64'(exp_done));
            chk("blk_ready_in_block", 64'(blk_ready), 64'd0);
            if (sel >= 0) begin
                chk("wave_id", wave_id[sel], issued);
                issued++;
                ptr_m = (sel + 1) % NS;
                timer[sel] = int'($urandom_range(hmin, hmax));
            end
            for (int i = 0; i < NS; i++) busy_m[i] = busy_nx[i];
            first = 1'b0;
            finished = exp_done;
        end
        chk("block_completed", 64'(finished), 64'd1);
        chk("num_waves_in_block", num_waves_in_block, n);
`ifdef WAVE_DISPATCH_PERF_EN
        chk("perf_waves_issued", perf_waves_issued - pw0, n);
        chk("perf_stall_cycles", perf_stall_cycles - ps0, stalls);
`endif
        tick();
        chk("idle_ready_after_done", 64'(blk_ready), 64'd1);
        chk("done_single_pulse", 64'(blk_done), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; blk_valid = 1'b0; blk_id = '0; simd_done = '0;
        num_threads = '0; block_dim = '0;
        #2;
        chk("rst_blk_ready", 64'(blk_ready), 64'd0);
        chk("rst_blk_done", 64'(blk_done), 64'd0);
        chk("rst_simd_start", 64'(simd_start), 64'd0);
        chk("rst_simd_ready", 64'(simd_ready), 64'd0);
        chk("rst_block_id", block_id, 64'd0);
        chk("rst_num_waves", num_waves_in_block, 64'd0);
        chk("rst_wave_id0", wave_id[0], 64'd0);
        chk("rst_wave_id1", wave_id[1], 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        tick();
        chk("idle_ready_after_reset", 64'(blk_ready), 64'd1);

        // Completion pulse on an idle SIMD must be ignored.
        simd_done = 2'b10;
        tick();
        simd_done = '0;
        chk("idle_done_ready", 64'(simd_ready), 64'd0);
        chk("idle_done_blk_done", 64'(blk_done), 64'd0);
        chk("idle_done_blk_ready", 64'(blk_ready), 64'd1);

        num_threads = 32'd100; block_dim = 32'd64;
        run_block(32'sd0, 0, 3);
        run_block(32'sd1, 1, 4);
        run_block(32'sd2, 0, 2);
        run_block(32'sh8000_0000, 0, 2);

        num_threads = 32'd1000; block_dim = 32'd128;
        run_block(32'sd0, 4, 4);

        // Maximal block: the rounding add must not overflow 32 bits.
        num_threads = 32'hFFFF_FFFF; block_dim = 32'hFFFF_FFFF;
        blk_valid = 1'b1; blk_id = 32'sd0;
        tick();
        blk_valid = 1'b0;
        tick();
        chk("waves_33bit_add", num_waves_in_block, 64'h0800_0000);
        chk("first_issue_simd0", 64'(simd_start), 64'(2'b01 << ptr_m));
        tick();
        chk("two_in_flight", 64'(simd_ready), 64'd3);

        rst = 1'b0;
        #1;
        chk("async_rst_ready", 64'(simd_ready), 64'd0);
        chk("async_rst_start", 64'(simd_start), 64'd0);
        chk("async_rst_num_waves", num_waves_in_block, 64'd0);
        chk("async_rst_wave_id0", wave_id[0], 64'd0);
        chk("async_rst_wave_id1", wave_id[1], 64'd0);
        chk("async_rst_blk_ready", 64'(blk_ready), 64'd0);
        tick();
        chk("rst_hold_blk_done", 64'(blk_done), 64'd0);
        rst = 1'b1;
        ptr_m = 0;
        tick();
        chk("ready_after_midblock_rst", 64'(blk_ready), 64'd1);

        num_threads = 32'd100; block_dim = 32'd64;
        run_block(32'sd1, 0, 2);

        for (int r = 0; r < 16; r++) begin
            num_threads = $urandom_range(0, 600);
            block_dim   = $urandom_range(1, 160);
            run_block($urandom_range(0, 6), 0, int'($urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wave_dispatcher
`default_nettype wire

// File: doc/wave_dispatcher.md
# wave_dispatcher

Splits one thread block, received from the block dispatcher, into wavefronts and issues them one at a time to `NUM_SIMD` SIMD units inside a compute unit. For each SIMD it drives `simd_start`, `simd_ready`, `block_id`, `wave_id` and `num_waves_in_block`, and it consumes that SIMD's `simd_done`. It reports block completion upstream once every wave of the block has retired.

## Interface
- `NUM_SIMD`, default 2: SIMD units served; a power of 2, ≥1.
- `WAVE_SIZE`, default 32: threads per wave; a power of 2.
- `clk` in, 1: the single clock.
- `rst` in, 1: asynchronous, active-low reset.
- `num_threads` in, 32: total kernel threads.
- `block_dim` in, 32: threads per block.
- `blk_valid` in, 1: block offer from the block dispatcher.
- `blk_id` in, 32 signed: offered block id.
- `blk_ready` out, 1: dispatcher can accept a block.
- `blk_done` out, 1: one-cycle pulse when the current block has fully retired.
- `simd_start` out, `NUM_SIMD`: one-cycle per-SIMD pulse that issues a wave.
- `simd_ready` out, `NUM_SIMD`: per-SIMD busy flag; high while the SIMD holds a wave.
- `simd_done` in, `NUM_SIMD`: per-SIMD completion pulse.
- `block_id` out, 32 signed: latched block id, shared by all SIMDs.
- `num_waves_in_block` out, 32: wave count of the current block, shared.
- `wave_id` out, `[NUM_SIMD]` x 32 signed: wave id held per SIMD.

## Operation
- States: IDLE, CALC, DISPATCH, DRAIN.
- IDLE
  - `blk_ready`=1.
  - On `blk_valid && blk_ready`: latch `blk_id` into `block_id` and go to CALC.
- CALC (exactly 1 cycle)
  - base = `block_id`*`block_dim`, unsigned and truncated to 32b.
  - threads = 0 if base ≥ `num_threads`, else min(`block_dim`, `num_threads`−base).
  - waves = (threads+`WAVE_SIZE`−1) >> log2(`WAVE_SIZE`). Compute this in 33b so the add cannot overflow.
  - Register waves into `num_waves_in_block` and clear `next_wave`.
  - If waves==0: pulse `blk_done` and return to IDLE. Otherwise go to DISPATCH.
- DISPATCH
  - Each cycle, the round-robin arbiter picks the first free SIMD (`simd_ready`=0), searching from the pointer.
  - For the picked SIMD i:
    - pulse `simd_start[i]`;
    - set `wave_id[i]`=`next_wave` and `simd_ready[i]`=1;
    - increment `next_wave`;
    - move the pointer to i+1 mod `NUM_SIMD`.
  - At most one wave is issued per cycle.
  - When the final wave (`num_waves_in_block`−1) issues, go to DRAIN.
  - If no SIMD is free, stall and hold all outputs.
- DRAIN
  - When all `simd_ready` bits are 0, pulse `blk_done` and go to IDLE.
- `simd_done[i]` clears `simd_ready[i]` on the next edge, in any state.
  - `simd_done` on a SIMD that is not busy is ignored.
  - A cleared SIMD becomes selectable one cycle later, because the arbiter sees registered `simd_ready`.
- `wave_id[i]` holds its value after completion until the SIMD is reissued.

## Timing
- Reset values:
  - outputs: `blk_ready`=0 during reset, 1 in IDLE afterwards; `blk_done`=0; `simd_start`=0; `simd_ready`=0; `block_id`=0; `num_waves_in_block`=0; `wave_id[*]`=0;
  - internal: pointer=0, state=IDLE.
- Acceptance to first `simd_start`: 2 edges (IDLE→CALC→DISPATCH, start asserted in the first DISPATCH cycle).
- With all SIMDs free, wave k issues in DISPATCH cycle k.
- Last `simd_done` to `blk_done`: 2 cycles (busy clears, then DRAIN detects all-free).
- `blk_ready`=0 in CALC, DISPATCH and DRAIN. A new block is accepted no earlier than the cycle after `blk_done`.
- Reset asserted mid-block: everything returns to reset values immediately. In-flight waves are abandoned, and no `blk_done` is issued.
- `num_threads`/`block_dim` are sampled in CALC only and must be stable from acceptance through CALC.

## Configuration
- `WAVE_DISPATCH_PERF_EN` defined:
  - adds outputs `perf_waves_issued` (32b) and `perf_stall_cycles` (32b);
  - waves_issued counts every `simd_start` bit;
  - stall_cycles counts DISPATCH cycles in which no SIMD was free;
  - both counters reset to 0 on `rst` and wrap at 2^32.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

## Structure
- Shared package `gpu_pkg`: the dispatcher state enum, `WAVE_SIZE`/lane constants, and a `clog2`-based shift constant for the wave division.
- One sub-module, `rr_free_arbiter`:
  - inputs: `NUM_SIMD` busy vector and pointer;
  - outputs: grant one-hot and a `found` flag;
  - purely combinational.
- The FSM, counters and per-SIMD registers live in `wave_dispatcher`.

## Test plan
- `num_threads`=100, `block_dim`=64, `NUM_SIMD`=2, block 0 → `num_waves_in_block`=2; `simd_start`=01 then 10 on consecutive cycles; `wave_id`={0,1}; `blk_done` 2 cycles after the last `simd_done`.
- Block 1, same config → 36 threads, 2 waves.
- Block 2 → 0 threads: `blk_done` in the CALC cycle, no `simd_start` ever.
- `block_dim`=128, `NUM_SIMD`=2, SIMD0 done withheld → waves 0 and 1 issue, then stall; pulsing `simd_done[0]` → wave 2 issues on SIMD0 two edges later; `perf_stall_cycles` increments during the stall.
- `simd_done[1]` while SIMD1 is idle → no state change and no `blk_done`.
- `rst` low during DISPATCH with waves in flight → all outputs 0 asynchronously; after release the dispatcher sits in IDLE with `blk_ready`=1 and accepts a new block normally.
